// File: rtl/uart2ahb_ctrl.sv
// uart2ahb_ctrl: AHB-lite slave that sequences the uart_tx/uart_rx cores.
// Ports: hclk/hrst_n clock and async active-low reset; m_h* AHB request inputs;
//   s_hrdata_o/s_hready_o/s_resp_o AHB response; tx_data_o/tx_valid_o/tx_ready_i
//   byte stream to uart_tx; rx_data_i/rx_valid_i/rx_ready_o byte stream from
//   uart_rx; tx_busy_i/rx_busy_i core status; rx_overrun_error_i/rx_frame_error_i
//   error pulses; prescale_o baud prescale from CTRL.
// Optional build macro UART2AHB_CTRL_IRQ_EN adds irq_o and CTRL[19:18] enables.

`timescale 1ns/1ps

// Decodes AHB transfers into TXDATA/RXDATA/STATUS/CTRL, buffers bytes in TX/RX FIFOs.
// Latency: zero-wait data phase; register/FIFO effects land on the completing edge.
// Backpressure: wait states while a TXDATA write finds the TX FIFO full (tx_en=1); ERROR otherwise.
module uart2ahb_ctrl #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          TX_DEPTH     = 4,
    parameter int          RX_DEPTH     = 4,
    parameter logic [15:0] PRESCALE_RST = 16'd27
) (
    input  logic                  hclk,
    input  logic                  hrst_n,
    input  logic [ADDR_WIDTH-1:0] m_haddr_i,
    input  logic [1:0]            m_htrans_i,
    input  logic                  m_hwrite_i,
    input  logic [2:0]            m_hsize_i,
    input  logic [DATA_WIDTH-1:0] m_hwdata_i,
    input  logic                  m_hsel_i,
    output logic [DATA_WIDTH-1:0] s_hrdata_o,
    output logic                  s_hready_o,
    output logic [1:0]            s_resp_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic                  tx_busy_i,
    input  logic                  rx_busy_i,
    input  logic                  rx_overrun_error_i,
    input  logic                  rx_frame_error_i,
`ifdef UART2AHB_CTRL_IRQ_EN
    output logic                  irq_o,
`endif
    output logic [15:0]           prescale_o
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE = 1;
    localparam logic [RAW:0] RX_ONE = 1;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic        write_q;
    logic [7:0]  hold_dat;

    logic [15:0] prescale;
    logic        tx_en;
    logic        rx_en;
    logic [1:0]  sticky;        // [0] overrun, [1] frame
    logic [19:0] ctrl_rd;
    logic [7:0]  status;

    // ------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [TAW:0] tx_wp, tx_rp;
    logic [7:0]   tx_mem [TX_DEPTH];
    logic         tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]   tx_push_dat;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
    assign tx_data_o  = tx_mem[tx_rp[TAW-1:0]];
    // Gated by tx_en combinationally so clearing it stops the stream at once.
    assign tx_valid_o = !tx_empty && tx_en;
    assign tx_pop     = tx_valid_o && tx_ready_i;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_ONE;
            if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
        end
    end

    always_ff @(posedge hclk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= tx_push_dat;
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [RAW:0] rx_wp, rx_rp;
    logic [7:0]   rx_mem [RX_DEPTH];
    logic         rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]   rx_head;

    assign rx_empty   = (rx_wp == rx_rp);
    assign rx_full    = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
    assign rx_head    = rx_mem[rx_rp[RAW-1:0]];
    assign rx_ready_o = !rx_full && rx_en;
    assign rx_push    = rx_valid_i && rx_ready_o;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_ONE;
            if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
        end
    end

    always_ff @(posedge hclk) begin
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_data_i;
    end

    // ------------------------------------------------------------------
    // Transfer decode
    // ------------------------------------------------------------------
    logic acc, in_data, tx_wr, rx_rd, stall_req, err_req, data_ok;
    logic status_wr, ctrl_wr, stall_done;

    assign acc        = m_hsel_i && m_htrans_i[1] && s_hready_o;
    assign in_data    = (state == ST_DATA);
    assign tx_wr      = in_data && write_q && (addr_q == A_TXDATA);
    assign rx_rd      = in_data && !write_q && (addr_q == A_RXDATA);
    assign stall_req  = tx_wr && tx_full && tx_en;
    // A full FIFO that is not draining would never free up, so fail instead of waiting.
    assign err_req    = (tx_wr && tx_full && !tx_en) || (rx_rd && rx_empty);
    assign data_ok    = in_data && !stall_req && !err_req;
    assign status_wr  = data_ok && write_q && (addr_q == A_STATUS);
    assign ctrl_wr    = data_ok && write_q && (addr_q == A_CTRL);
    assign stall_done = (state == ST_STALL) && !tx_full;

    // A held write lands on the cycle the stall releases, using the captured byte.
    assign tx_push     = (tx_wr && !tx_full) || stall_done;
    assign tx_push_dat = (state == ST_STALL) ? hold_dat : m_hwdata_i[7:0];
    assign rx_pop      = rx_rd && !rx_empty;

    always_comb begin
        s_hready_o = 1'b1;
        case (state)
            ST_DATA:  s_hready_o = !(stall_req || err_req);
            ST_STALL: s_hready_o = !tx_full;
            ST_ERR1:  s_hready_o = 1'b0;
            default:  s_hready_o = 1'b1;
        endcase
    end

    assign s_resp_o = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            hold_dat <= '0;
        end else begin
            // acc can only be high on a cycle that completes the previous transfer.
            if (acc) begin
                addr_q  <= m_haddr_i[3:2];
                write_q <= m_hwrite_i;
            end
            if (stall_req) hold_dat <= m_hwdata_i[7:0];
            case (state)
                ST_DATA: begin
                    if (err_req)        state <= ST_ERR1;
                    else if (stall_req) state <= ST_STALL;
                    else                state <= acc ? ST_DATA : ST_IDLE;
                end
                ST_STALL: begin
                    if (!tx_full) state <= acc ? ST_DATA : ST_IDLE;
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= acc ? ST_DATA : ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CTRL / STATUS registers
    // ------------------------------------------------------------------
    logic [1:0] sticky_clr;
    assign sticky_clr = status_wr ? m_hwdata_i[7:6] : 2'b00;

`ifdef UART2AHB_CTRL_IRQ_EN
    logic ie_tx, ie_rx, irq_q;
    assign irq_o   = irq_q;
    assign ctrl_rd = {ie_rx, ie_tx, rx_en, tx_en, prescale};
`else
    assign ctrl_rd = {2'b00, rx_en, tx_en, prescale};
`endif

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            prescale <= PRESCALE_RST;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            sticky   <= 2'b00;
`ifdef UART2AHB_CTRL_IRQ_EN
            ie_tx    <= 1'b0;
            ie_rx    <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            if (ctrl_wr) begin
                prescale <= m_hwdata_i[15:0];
                tx_en    <= m_hwdata_i[16];
                rx_en    <= m_hwdata_i[17];
`ifdef UART2AHB_CTRL_IRQ_EN
                ie_tx    <= m_hwdata_i[18];
                ie_rx    <= m_hwdata_i[19];
`endif
            end
            // A new error pulse beats a simultaneous write-one-to-clear.
            sticky <= (sticky & ~sticky_clr) | {rx_frame_error_i, rx_overrun_error_i};
`ifdef UART2AHB_CTRL_IRQ_EN
            irq_q  <= (ie_tx && tx_empty) || (ie_rx && (!rx_empty || (|sticky)));
`endif
        end
    end

    assign prescale_o = prescale;
    assign status = {sticky[1], sticky[0], rx_busy_i, tx_busy_i,
                     rx_full, rx_empty, tx_empty, tx_full};

    // Read data reflects live register values during the data phase only.
    always_comb begin
        s_hrdata_o = '0;
        if (in_data && !write_q) begin
            case (addr_q)
                A_RXDATA: if (!rx_empty) s_hrdata_o = DATA_WIDTH'(rx_head);
                A_STATUS: s_hrdata_o = DATA_WIDTH'(status);
                A_CTRL:   s_hrdata_o = DATA_WIDTH'(ctrl_rd);
                default:  s_hrdata_o = '0;
            endcase
        end
    end

    // Address bits outside [3:2], hsize, htrans[0] and upper write data carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{m_haddr_i[ADDR_WIDTH-1:4], m_haddr_i[1:0], m_htrans_i[0],
                         m_hsize_i, m_hwdata_i[DATA_WIDTH-1:16]};

endmodule

// File: tb/tb_uart2ahb_ctrl.sv
// Testbench for uart2ahb_ctrl: drives AHB transfers and UART-side byte streams,
// compares read data/responses and transmitted bytes against queued expectations.

`timescale 1ns/1ps

module tb_uart2ahb_ctrl;

    logic        hclk = 1'b0;
    logic        hrst_n = 1'b0;
    logic [31:0] m_haddr_i = '0;
    logic [1:0]  m_htrans_i = '0;
    logic        m_hwrite_i = 1'b0;
    logic [2:0]  m_hsize_i = 3'b010;
    logic [31:0] m_hwdata_i = '0;
    logic        m_hsel_i = 1'b0;
    logic [31:0] s_hrdata_o;
    logic        s_hready_o;
    logic [1:0]  s_resp_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        tx_busy_i = 1'b0;
    logic        rx_busy_i = 1'b0;
    logic        rx_overrun_error_i = 1'b0;
    logic        rx_frame_error_i = 1'b0;
    logic [15:0] prescale_o;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  resp;
    } rd_exp_t;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    rd_exp_t    rd_q[$];

    uart2ahb_ctrl dut (
        .hclk               (hclk),
        .hrst_n             (hrst_n),
        .m_haddr_i          (m_haddr_i),
        .m_htrans_i         (m_htrans_i),
        .m_hwrite_i         (m_hwrite_i),
        .m_hsize_i          (m_hsize_i),
        .m_hwdata_i         (m_hwdata_i),
        .m_hsel_i           (m_hsel_i),
        .s_hrdata_o         (s_hrdata_o),
        .s_hready_o         (s_hready_o),
        .s_resp_o           (s_resp_o),
        .tx_data_o          (tx_data_o),
        .tx_valid_o         (tx_valid_o),
        .tx_ready_i         (tx_ready_i),
        .rx_data_i          (rx_data_i),
        .rx_valid_i         (rx_valid_i),
        .rx_ready_o         (rx_ready_o),
        .tx_busy_i          (tx_busy_i),
        .rx_busy_i          (rx_busy_i),
        .rx_overrun_error_i (rx_overrun_error_i),
        .rx_frame_error_i   (rx_frame_error_i),
        .prescale_o         (prescale_o)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    // Single AHB transfer; returns data-phase results once hready rises.
    task automatic ahb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdat,
                            output logic [31:0] rdat, output logic [1:0] resp,
                            output logic [1:0] wait_resp, output int waits);
        int n;
        @(posedge hclk); #1;
        m_hsel_i   = 1'b1;
        m_htrans_i = 2'b10;
        m_hwrite_i = wr;
        m_haddr_i  = {28'h0, addr};
        n = 0;
        while (!s_hready_o && n < 100) begin
            @(posedge hclk); #1;
            n++;
        end
        chk("addr_ready", 32'(s_hready_o), 32'h1);
        @(posedge hclk); #1;
        m_hsel_i   = 1'b0;
        m_htrans_i = 2'b00;
        m_hwdata_i = wdat;
        waits = 0;
        wait_resp = 2'b00;
        while (!s_hready_o && waits < 100) begin
            wait_resp = s_resp_o;
            @(posedge hclk); #1;
            waits++;
        end
        chk("data_ready", 32'(s_hready_o), 32'h1);
        rdat = s_hrdata_o;
        resp = s_resp_o;
    endtask

    task automatic ahb_rd(input string tag, input logic [3:0] addr,
                          input logic [31:0] exp_dat, input logic [1:0] exp_resp);
        logic [31:0] rd;
        logic [1:0]  rs, ws;
        int          w;
        rd_exp_t     e;
        rd_q.push_back({exp_dat, exp_resp});
        ahb_xfer(1'b0, addr, 32'h0, rd, rs, ws, w);
        e = rd_q.pop_front();
        chk({tag, "_dat"}, rd, e.dat);
        chk({tag, "_resp"}, {30'h0, rs}, {30'h0, e.resp});
        if (e.resp == 2'b01) chk({tag, "_err1"}, {30'h0, ws}, 32'h1);
    endtask

    task automatic ahb_wr(input string tag, input logic [3:0] addr, input logic [31:0] wdat,
                          input logic [1:0] exp_resp, output int waits);
        logic [31:0] rd;
        logic [1:0]  rs, ws;
        ahb_xfer(1'b1, addr, wdat, rd, rs, ws, waits);
        chk({tag, "_resp"}, {30'h0, rs}, {30'h0, exp_resp});
        chk({tag, "_rdat"}, rd, 32'h0);
        if (exp_resp == 2'b01) chk({tag, "_err1"}, {30'h0, ws}, 32'h1);
    endtask

    task automatic rx_read(input string tag);
        if (rx_q.size() > 0) ahb_rd(tag, 4'h4, {24'h0, rx_q.pop_front()}, 2'b00);
        else                 ahb_rd(tag, 4'h4, 32'h0, 2'b01);
    endtask

    // Transmit-side monitor: every accepted byte must match the oldest expected one.
    always @(negedge hclk) begin
        if (hrst_n && tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_q.size()), 32'h1);
            else                  chk("tx_byte", {24'h0, tx_data_o}, {24'h0, tx_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int w;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hready", 32'(s_hready_o), 32'h1);
        chk("rst_resp", {30'h0, s_resp_o}, 32'h0);
        chk("rst_hrdata", s_hrdata_o, 32'h0);
        chk("rst_txvld", 32'(tx_valid_o), 32'h0);
        chk("rst_rxrdy", 32'(rx_ready_o), 32'h0);
        chk("rst_prescale", {16'h0, prescale_o}, 32'h1B);
        hrst_n = 1'b1;

        ahb_rd("rst_ctrl", 4'hC, 32'h0000001B, 2'b00);
        ahb_rd("rst_status", 4'h8, 32'h06, 2'b00);
        ahb_rd("txdata_rd", 4'h0, 32'h0, 2'b00);

        // Enable both directions, stream two bytes out.
        tx_ready_i = 1'b1;
        ahb_wr("ctrl_en", 4'hC, 32'h00030010, 2'b00, w);
        ahb_rd("ctrl_rb", 4'hC, 32'h00030010, 2'b00);
        chk("prescale", {16'h0, prescale_o}, 32'h10);
        tx_q.push_back(8'h41);
        ahb_wr("tx41", 4'h0, 32'h41, 2'b00, w);
        tx_q.push_back(8'h42);
        ahb_wr("tx42", 4'h0, 32'h42, 2'b00, w);
        repeat (5) @(posedge hclk);
        #1;
        chk("tx_drain1", 32'(tx_q.size()), 32'h0);

        // Fill the TX FIFO, then a fifth write must stall until one byte drains.
        tx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(8'h10 + 8'(i));
            ahb_wr("tx_fill", 4'h0, 32'h10 + 32'(i), 2'b00, w);
        end
        tx_q.push_back(8'h14);
        fork
            ahb_wr("tx_stall", 4'h0, 32'h14, 2'b00, w);
            begin
                repeat (6) @(posedge hclk);
                #1 tx_ready_i = 1'b1;
                @(posedge hclk);
                #1 tx_ready_i = 1'b0;
            end
        join
        chk("stall_waited", 32'(w >= 3), 32'h1);
        ahb_rd("status_full", 4'h8, 32'h05, 2'b00);

        // tx_en off with a full FIFO: write errors, contents retained.
        ahb_wr("ctrl_txoff", 4'hC, 32'h00020010, 2'b00, w);
        ahb_rd("ctrl_rb2", 4'hC, 32'h00020010, 2'b00);
        chk("txvld_off", 32'(tx_valid_o), 32'h0);
        ahb_wr("tx_full_err", 4'h0, 32'h99, 2'b01, w);
        ahb_rd("status_kept", 4'h8, 32'h05, 2'b00);
        tx_ready_i = 1'b1;
        ahb_wr("ctrl_txon", 4'hC, 32'h00030010, 2'b00, w);
        repeat (8) @(posedge hclk);
        #1;
        chk("tx_drain2", 32'(tx_q.size()), 32'h0);
        ahb_rd("status_empty", 4'h8, 32'h06, 2'b00);

        // Receive two bytes, read them back, third read errors.
        chk("rx_rdy", 32'(rx_ready_o), 32'h1);
        @(posedge hclk); #1;
        rx_valid_i = 1'b1; rx_data_i = 8'h55; rx_q.push_back(8'h55);
        @(posedge hclk); #1;
        rx_data_i = 8'hAA; rx_q.push_back(8'hAA);
        @(posedge hclk); #1;
        rx_valid_i = 1'b0;
        ahb_rd("status_rx", 4'h8, 32'h02, 2'b00);
        rx_read("rx_rd0");
        rx_read("rx_rd1");
        rx_read("rx_rd_empty");

        // Busy flags and sticky errors.
        tx_busy_i = 1'b1; rx_busy_i = 1'b1;
        ahb_rd("status_busy", 4'h8, 32'h36, 2'b00);
        tx_busy_i = 1'b0; rx_busy_i = 1'b0;
        @(posedge hclk); #1 rx_frame_error_i = 1'b1;
        @(posedge hclk); #1 rx_frame_error_i = 1'b0;
        ahb_rd("status_frame", 4'h8, 32'h86, 2'b00);
        ahb_wr("w1c_frame", 4'h8, 32'h80, 2'b00, w);
        ahb_rd("status_frame_clr", 4'h8, 32'h06, 2'b00);
        @(posedge hclk); #1 rx_overrun_error_i = 1'b1;
        @(posedge hclk); #1 rx_overrun_error_i = 1'b0;
        ahb_rd("status_ovr", 4'h8, 32'h46, 2'b00);
        ahb_wr("w1c_wrong", 4'h8, 32'h80, 2'b00, w);
        ahb_rd("status_ovr_kept", 4'h8, 32'h46, 2'b00);
        ahb_wr("w1c_ovr", 4'h8, 32'h40, 2'b00, w);
        ahb_rd("status_ovr_clr", 4'h8, 32'h06, 2'b00);

        // Reset discards FIFO contents and restores CTRL.
        tx_ready_i = 1'b0;
        ahb_wr("tx_pre_rst", 4'h0, 32'h77, 2'b00, w);
        @(posedge hclk); #1;
        chk("txvld_pre_rst", 32'(tx_valid_o), 32'h1);
        hrst_n = 1'b0;
        #1;
        chk("rst2_txvld", 32'(tx_valid_o), 32'h0);
        chk("rst2_prescale", {16'h0, prescale_o}, 32'h1B);
        @(posedge hclk); #1;
        hrst_n = 1'b1;
        ahb_rd("rst2_status", 4'h8, 32'h06, 2'b00);
        ahb_rd("rst2_ctrl", 4'hC, 32'h1B, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
